// File: rtl/branch_resolve_if.sv
// branch_resolve_if: flag input, branch request/response and flush signals between cmp, branch resolve and fetch
//   flag, flag_we                  : flags from the cmp stage and their write enable
//   req_valid/ready, req_cond/pc/target : branch request handshake and payload
//   rsp_valid, rsp_taken, rsp_next_pc, cond_err : one-cycle branch result
//   flush                          : fetch flush window
//   flags_q                        : current flags register
//   master modport drives requests; slave modport is the branch_resolve side
interface branch_resolve_if #(
   parameter int PC_W = 32
);
   logic [3:0]      flag;
   logic            flag_we;
   logic            req_valid;
   logic            req_ready;
   logic [3:0]      req_cond;
   logic [PC_W-1:0] req_pc;
   logic [PC_W-1:0] req_target;
   logic            rsp_valid;
   logic            rsp_taken;
   logic [PC_W-1:0] rsp_next_pc;
   logic            cond_err;
   logic            flush;
   logic [3:0]      flags_q;
   modport master (
      output flag, flag_we, req_valid, req_cond, req_pc, req_target,
      input  req_ready, rsp_valid, rsp_taken, rsp_next_pc, cond_err, flush, flags_q
   );
   modport slave (
      input  flag, flag_we, req_valid, req_cond, req_pc, req_target,
      output req_ready, rsp_valid, rsp_taken, rsp_next_pc, cond_err, flush, flags_q
   );
endinterface

// File: rtl/branch_resolve.sv
// branch_resolve: holds cmp flags, resolves branch requests against a condition code, drives next PC and a fetch flush window
//   clk, rst  : clock (rising edge), asynchronous active-high reset
//   br        : branch_resolve_if.slave (flags in, request handshake, response, flush, flags_q)
//   BR_STATS_EN (macro): adds saturating taken_cnt / nottaken_cnt outputs of CNT_W bits
module branch_resolve #(
   parameter int PC_W         = 32,
   parameter int FLUSH_CYCLES = 2
`ifdef BR_STATS_EN
   ,
   parameter int CNT_W        = 16
`endif
) (
   input logic             clk,
   input logic             rst,
   branch_resolve_if.slave br
`ifdef BR_STATS_EN
   ,
   output logic [CNT_W-1:0] taken_cnt,
   output logic [CNT_W-1:0] nottaken_cnt
`endif
);
   localparam int CW = FLUSH_CYCLES > 1 ? $clog2(FLUSH_CYCLES) : 1;
   typedef enum logic [1:0] {IDLE, RESOLVE, FLUSH} state_t;
   state_t        state;
   logic [CW-1:0] cnt;
   logic [3:0]    eff;
   logic [15:0]   tbl;
   logic          taken;
   logic          err;
   // Truth table of every condition code indexed by cond; bypass uses the incoming flag
   always_comb begin
      eff   = br.flag_we ? br.flag : br.flags_q;
      tbl   = {5'b0, 1'b1, ~eff[0], eff[0], ~eff[1], eff[1], ~eff[3] & ~eff[2],
               eff[3] | eff[2], ~eff[3], eff[3], ~eff[2], eff[2]};
      taken = tbl[br.req_cond];
      err   = &br.req_cond[3:2];
   end
   // Response fields are registered at accept so they appear in the RESOLVE cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= IDLE;
         cnt            <= '0;
         br.flags_q     <= '0;
         br.req_ready   <= 1'b1;
         br.rsp_valid   <= 1'b0;
         br.rsp_taken   <= 1'b0;
         br.rsp_next_pc <= '0;
         br.cond_err    <= 1'b0;
         br.flush       <= 1'b0;
      end else begin
         if (br.flag_we) br.flags_q <= br.flag;
         br.rsp_valid   <= 1'b0;
         br.rsp_taken   <= 1'b0;
         br.rsp_next_pc <= '0;
         br.cond_err    <= 1'b0;
         case (state)
            IDLE: if (br.req_valid) begin
               state          <= RESOLVE;
               br.req_ready   <= 1'b0;
               br.rsp_valid   <= 1'b1;
               br.rsp_taken   <= taken;
               br.rsp_next_pc <= taken ? br.req_target : br.req_pc + PC_W'(4);
               br.cond_err    <= err;
               br.flush       <= taken;
            end
            RESOLVE: if (br.rsp_taken && FLUSH_CYCLES > 1) begin
               state <= FLUSH;
               cnt   <= CW'(FLUSH_CYCLES - 1);
            end else begin
               state        <= IDLE;
               br.req_ready <= 1'b1;
               br.flush     <= 1'b0;
            end
            FLUSH: if (cnt == CW'(1)) begin
               state        <= IDLE;
               br.req_ready <= 1'b1;
               br.flush     <= 1'b0;
            end else begin
               cnt <= cnt - CW'(1);
            end
            default: state <= IDLE;
         endcase
      end
   end
`ifdef BR_STATS_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         taken_cnt    <= '0;
         nottaken_cnt <= '0;
      end else if (br.rsp_valid) begin
         if (br.rsp_taken && !(&taken_cnt)) taken_cnt <= taken_cnt + CNT_W'(1);
         if (!br.rsp_taken && !(&nottaken_cnt)) nottaken_cnt <= nottaken_cnt + CNT_W'(1);
      end
   end
`endif
endmodule

// File: tb/tb_branch_resolve.sv
// tb_branch_resolve: vector table, reset/flush sequences and randomized model check of branch_resolve
module tb_branch_resolve;
   localparam int PC_W = 32;
   localparam int FC   = 2;
`ifdef BR_STATS_EN
   localparam int CNT_W = 2;
   logic [CNT_W-1:0] taken_cnt, nottaken_cnt;
`endif
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;
   branch_resolve_if #(.PC_W(PC_W)) br();
   branch_resolve #(
      .PC_W(PC_W),
      .FLUSH_CYCLES(FC)
`ifdef BR_STATS_EN
      ,
      .CNT_W(CNT_W)
`endif
   ) dut (
      .clk(clk),
      .rst(rst),
      .br(br)
`ifdef BR_STATS_EN
      ,
      .taken_cnt(taken_cnt),
      .nottaken_cnt(nottaken_cnt)
`endif
   );
   int n_chk = 0;
   int n_fail = 0;
   typedef struct {
      logic [3:0]  pre;
      logic        we;
      logic [3:0]  bf;
      logic [3:0]  cond;
      logic [31:0] pc;
      logic [31:0] tgt;
      logic        tk;
      logic        err;
      logic [31:0] npc;
      logic [3:0]  fq;
   } vec_t;
   vec_t vt[10];
   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask
   // Condition meaning straight from the condition-code table
   function automatic logic ref_taken(input logic [3:0] f, input logic [3:0] c);
      logic n, z, cy, v;
      n = f[3]; z = f[2]; cy = f[1]; v = f[0];
      case (c)
         4'd0:  return z;
         4'd1:  return !z;
         4'd2:  return n;
         4'd3:  return !n;
         4'd4:  return n || z;
         4'd5:  return !n && !z;
         4'd6:  return cy;
         4'd7:  return !cy;
         4'd8:  return v;
         4'd9:  return !v;
         4'd10: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic idle_in;
      br.req_valid = 1'b0;
      br.flag_we   = 1'b0;
   endtask
   int fl, rl, cyc, ready_at, rsp_cyc, fs, fe;
   logic [3:0] mflags, eff;
   logic e_tk, e_err, acc;
   logic [31:0] e_pc;
   initial begin
      vt[0] = '{4'b0100, 1'b0, 4'b0000, 4'd0,  32'h100,       32'h200, 1'b1, 1'b0, 32'h200,   4'b0100};
      vt[1] = '{4'b0000, 1'b1, 4'b1000, 4'd2,  32'h300,       32'h400, 1'b1, 1'b0, 32'h400,   4'b1000};
      vt[2] = '{4'b0100, 1'b0, 4'b0000, 4'd5,  32'hFFFF_FFFC, 32'h10,  1'b0, 1'b0, 32'h0,     4'b0100};
      vt[3] = '{4'b0000, 1'b0, 4'b0000, 4'd13, 32'h500,       32'h600, 1'b0, 1'b1, 32'h504,   4'b0000};
      vt[4] = '{4'b0010, 1'b0, 4'b0000, 4'd6,  32'h20,        32'h40,  1'b1, 1'b0, 32'h40,    4'b0010};
      vt[5] = '{4'b0001, 1'b0, 4'b0000, 4'd9,  32'h20,        32'h40,  1'b0, 1'b0, 32'h24,    4'b0001};
      vt[6] = '{4'b1001, 1'b0, 4'b0000, 4'd10, 32'h1000,      32'h80,  1'b1, 1'b0, 32'h80,    4'b1001};
      vt[7] = '{4'b1111, 1'b0, 4'b0000, 4'd11, 32'h1000,      32'h80,  1'b0, 1'b0, 32'h1004,  4'b1111};
      vt[8] = '{4'b0000, 1'b0, 4'b0000, 4'd4,  32'h2000,      32'h80,  1'b0, 1'b0, 32'h2004,  4'b0000};
      vt[9] = '{4'b1111, 1'b1, 4'b0000, 4'd1,  32'h2000,      32'h88,  1'b1, 1'b0, 32'h88,    4'b0000};
      br.flag = '0; br.flag_we = 1'b0; br.req_valid = 1'b0;
      br.req_cond = '0; br.req_pc = '0; br.req_target = '0;
      tick; tick;
      chk("rst_ready", br.req_ready, 1);
      chk("rst_rsp_valid", br.rsp_valid, 0);
      chk("rst_flush", br.flush, 0);
      chk("rst_flags", br.flags_q, 0);
      chk("rst_taken", br.rsp_taken, 0);
      chk("rst_next_pc", br.rsp_next_pc, 0);
      chk("rst_cond_err", br.cond_err, 0);
      rst = 1'b0;
      // Asynchronous reset landing inside the flush window
      br.flag_we = 1'b1; br.flag = 4'b0100; br.req_valid = 1'b1;
      br.req_cond = 4'd10; br.req_pc = 32'h40; br.req_target = 32'h80;
      tick;
      idle_in;
      tick;
      chk("midflush_flush_before", br.flush, 1);
      chk("midflush_ready_before", br.req_ready, 0);
      #2 rst = 1'b1;
      #1;
      chk("midflush_rst_flush", br.flush, 0);
      chk("midflush_rst_ready", br.req_ready, 1);
      chk("midflush_rst_flags", br.flags_q, 0);
      chk("midflush_rst_rsp_valid", br.rsp_valid, 0);
      tick;
      rst = 1'b0;
      tick;
      chk("midflush_after_rsp_valid", br.rsp_valid, 0);
      chk("midflush_after_ready", br.req_ready, 1);
      foreach (vt[i]) begin
         br.flag_we = 1'b1; br.flag = vt[i].pre; br.req_valid = 1'b0;
         tick;
         chk($sformatf("v%0d_ready", i), br.req_ready, 1);
         br.flag_we = vt[i].we; br.flag = vt[i].bf; br.req_valid = 1'b1;
         br.req_cond = vt[i].cond; br.req_pc = vt[i].pc; br.req_target = vt[i].tgt;
         tick;
         idle_in;
         chk($sformatf("v%0d_rsp_valid", i), br.rsp_valid, 1);
         chk($sformatf("v%0d_taken", i), br.rsp_taken, vt[i].tk);
         chk($sformatf("v%0d_cond_err", i), br.cond_err, vt[i].err);
         chk($sformatf("v%0d_next_pc", i), br.rsp_next_pc, vt[i].npc);
         chk($sformatf("v%0d_flags_q", i), br.flags_q, vt[i].fq);
         fl = br.flush ? 1 : 0;
         rl = br.req_ready ? 0 : 1;
         for (int k = 0; k < 10; k++) begin
            tick;
            if (k == 0) begin
               chk($sformatf("v%0d_rsp_drop", i), br.rsp_valid, 0);
               chk($sformatf("v%0d_err_drop", i), br.cond_err, 0);
            end
            if (br.req_ready) break;
            rl++;
            if (br.flush) fl++;
         end
         chk($sformatf("v%0d_ready_back", i), br.req_ready, 1);
         chk($sformatf("v%0d_flush_end", i), br.flush, 0);
         chk($sformatf("v%0d_flush_len", i), 64'(fl), vt[i].tk ? 64'(FC) : 64'd0);
         chk($sformatf("v%0d_ready_low", i), 64'(rl), vt[i].tk ? 64'(FC) : 64'd1);
      end
`ifdef BR_STATS_EN
      rst = 1'b1;
      tick;
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         br.req_valid = 1'b1; br.req_cond = 4'd10; br.req_pc = 32'h10; br.req_target = 32'h20;
         tick;
         idle_in;
         for (int k = 0; k < 10 && !br.req_ready; k++) tick;
      end
      tick;
      chk("stats_taken_cnt", taken_cnt, 3);
      chk("stats_nottaken_cnt", nottaken_cnt, 0);
`endif
      rst = 1'b1;
      tick;
      rst = 1'b0;
      mflags = '0; ready_at = 0; rsp_cyc = -1; fs = -1; fe = -2;
      e_tk = 0; e_err = 0; e_pc = '0;
      for (cyc = 0; cyc < 800; cyc++) begin
         chk("rnd_ready", br.req_ready, cyc >= ready_at);
         chk("rnd_flush", br.flush, cyc >= fs && cyc <= fe);
         chk("rnd_rsp_valid", br.rsp_valid, cyc == rsp_cyc);
         chk("rnd_taken", br.rsp_taken, cyc == rsp_cyc ? e_tk : 1'b0);
         chk("rnd_cond_err", br.cond_err, cyc == rsp_cyc ? e_err : 1'b0);
         chk("rnd_next_pc", br.rsp_next_pc, cyc == rsp_cyc ? e_pc : 32'h0);
         chk("rnd_flags_q", br.flags_q, mflags);
         br.req_valid  = $urandom_range(0, 2) != 0;
         br.flag_we    = $urandom_range(0, 3) == 0;
         br.flag       = 4'($urandom);
         br.req_cond   = 4'($urandom_range(0, 15));
         br.req_pc     = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom;
         br.req_target = $urandom;
         acc = br.req_valid && cyc >= ready_at;
         if (acc) begin
            eff     = br.flag_we ? br.flag : mflags;
            e_tk    = ref_taken(eff, br.req_cond);
            e_err   = br.req_cond >= 4'd12;
            e_pc    = e_tk ? br.req_target : br.req_pc + 32'd4;
            rsp_cyc = cyc + 1;
            if (e_tk) begin
               fs = cyc + 1; fe = cyc + FC; ready_at = cyc + 1 + FC;
            end else begin
               ready_at = cyc + 2;
            end
         end
         if (br.flag_we) mflags = br.flag;
         tick;
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
